seven_segment_mux: RTL and testbench

Parametrised, time-multiplexed driver for a DIGITS-wide common-anode/cathode seven-segment display. Accepts a packed hex value with per-digit decimal-point and blank flags, decodes each nibble to segments {A,B,C,D,E,F,G,DP}, and scans digits at a programmable refresh rate with anti-ghosting dead time. New values are accepted through a load strobe and applied only at frame boundaries, so a frame never mixes two values. It sits between the board top level and the display pins, in place of the per-pin combinational decoder.

---
 rtl/seven_segment_mux.sv | 133 +++++++++++++
 tb/tb_seven_segment_mux.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver with frame-aligned value updates and dead time.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_segment_mux #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int DEAD           = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_C   = CW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   pend_flag;
  logic [4*DIGITS-1:0]    pend_val;
  logic [DIGITS-1:0]      pend_dp;
  logic [DIGITS-1:0]      pend_blank;
  logic [4*DIGITS-1:0]    sh_val;
  logic [DIGITS-1:0]      sh_dp;
  logic [DIGITS-1:0]      sh_blank;

  logic                   boundary;
  logic [3:0]             nib;
  logic [DIGITS-1:0]      hide;
  logic                   upper_zero;
  logic [7:0]             seg_l;
  logic [DIGITS-1:0]      an_l;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1111011;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b0011111;
      4'hC: decode = 7'b1001110;
      4'hD: decode = 7'b0111101;
      4'hE: decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  assign boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);

  always_comb begin
    nib        = sh_val[idx*4 +: 4];
    hide       = sh_blank;
    upper_zero = 1'b1;
`ifdef SEVEN_SEG_LZB_EN
    // Walk down from the top digit; a digit hides while everything above it is zero.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (sh_val[4*i +: 4] == 4'h0);
      if (upper_zero && !sh_dp[i]) hide[i] = 1'b1;
    end
`endif
    seg_l = {decode(nib), sh_dp[idx]};
    if (hide[idx]) seg_l = 8'h00;
    an_l = '0;
    if (cnt >= DEAD_C) an_l[idx] = 1'b1;
    else               seg_l     = 8'h00;
  end

  // load is a one-cycle strobe with no ready: it is always taken, either straight
  // into the shadow on the boundary cycle or into the pending register (last wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pend_flag  <= 1'b0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      sh_val     <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      frame_done <= 1'b0;
      seg        <= {8{SEG_INV}};
      an         <= {DIGITS{AN_INV}};
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      frame_done <= boundary;
      seg        <= seg_l ^ {8{SEG_INV}};
      an         <= an_l ^ {DIGITS{AN_INV}};
      if (boundary) begin
        if (load) begin
          sh_val   <= value;
          sh_dp    <= dp_in;
          sh_blank <= blank_in;
        end else if (pend_flag) begin
          sh_val   <= pend_val;
          sh_dp    <= pend_dp;
          sh_blank <= pend_blank;
        end
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_flag  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Scoreboard bench for seven_segment_mux: per-cycle expected outputs queued by the driver,
// checked by a negedge monitor on an active-high and an active-low instance.
module tb_seven_segment_mux;
  localparam int DIGITS = 4;
  localparam int RD     = 8;
  localparam int DEAD   = 2;
  localparam int FRAME  = DIGITS * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic [7:0]  seg, seg_n;
  logic [3:0]  an, an_n;
  logic        frame_done, frame_done_n;

  int checks = 0;
  int errors = 0;
  int scyc = 0;
  logic mon_en = 1'b0;
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  seven_segment_mux #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .DEAD(DEAD),
                      .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .seg(seg), .an(an), .frame_done(frame_done));

  seven_segment_mux #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .DEAD(DEAD),
                      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_inv (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .seg(seg_n), .an(an_n), .frame_done(frame_done_n));

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [7:0] digit_seg(input logic [15:0] v, input logic [3:0] dp,
                                           input logic [3:0] bl, input int d);
    logic hide;
    hide = bl[d];
`ifdef SEVEN_SEG_LZB_EN
    if (d > 0 && !dp[d] && ((v >> (4*d)) == 16'h0)) hide = 1'b1;
`endif
    if (hide) return 8'h00;
    return {seg_code(v[4*d +: 4]), dp[d]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic push_reset();
    exp_q.push_back(13'h0);
  endtask

  // Queue the outputs produced by the first nstates state cycles of a frame.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] bl, input int nstates);
    for (int j = 0; j < nstates; j++) begin
      int d, c;
      logic [3:0] a;
      logic [7:0] s;
      d = j / RD;
      c = j % RD;
      a = (c >= DEAD) ? 4'(1 << d) : 4'h0;
      s = (c >= DEAD) ? digit_seg(v, dp, bl, d) : 8'h00;
      exp_q.push_back({(j == FRAME - 1), a, s});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    scyc++;
  endtask

  task automatic load_at(input int t, input logic [15:0] v, input logic [3:0] dp,
                         input logic [3:0] bl);
    while (scyc < t) step();
    value = v; dp_in = dp; blank_in = bl; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL queue_underflow at t=%0t: got no expected entry", $time);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("out", {3'b0, frame_done, an, seg}, {3'b0, e});
        check("out_inv", {3'b0, frame_done_n, an_n, seg_n}, {3'b0, e[12], ~e[11:0]});
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold", {3'b0, frame_done, an, seg}, 16'h0000);
    check("rst_hold_inv", {3'b0, frame_done_n, an_n, seg_n}, {3'b0, 1'b0, 4'hF, 8'hFF});

    push_reset();
    push_frame(16'h0000, 4'h0, 4'h0, FRAME);   // F0: reset shadow
    push_frame(16'h1234, 4'h0, 4'h0, FRAME);   // F1
    push_frame(16'h5555, 4'h0, 4'h0, FRAME);   // F2: last of two loads wins
    push_frame(16'hFFFF, 4'h0, 4'h0, FRAME);   // F3: loaded in boundary cycle
    push_frame(16'h8888, 4'h1, 4'h4, FRAME);   // F4
    push_frame(16'h0000, 4'h0, 4'h0, FRAME);   // F5
    push_frame(16'h0012, 4'h0, 4'h0, FRAME);   // F6
    push_frame(16'h0012, 4'h0, 4'h0, 12);      // F7 up to mid-slot reset

    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    scyc = 0;

    load_at(0*FRAME + 5,  16'h1234, 4'h0, 4'h0);
    load_at(1*FRAME + 3,  16'hAAAA, 4'h0, 4'h0);
    load_at(1*FRAME + 20, 16'h5555, 4'h0, 4'h0);
    load_at(2*FRAME + 31, 16'hFFFF, 4'h0, 4'h0);
    load_at(3*FRAME + 10, 16'h8888, 4'h1, 4'h4);
    load_at(4*FRAME + 15, 16'h0000, 4'h0, 4'h0);
    load_at(5*FRAME + 8,  16'h0012, 4'h0, 4'h0);
    load_at(7*FRAME + 5,  16'h3333, 4'h0, 4'h0);

    // Mid-slot reset with a coincident load that must be discarded.
    while (scyc < 7*FRAME + 12) step();
    rst = 1'b1;
    value = 16'h7777; load = 1'b1;
    step();
    mon_en = 1'b0;
    load = 1'b0;
    @(negedge clk);
    check("rst_mid", {3'b0, frame_done, an, seg}, 16'h0000);
    check("rst_mid_inv", {3'b0, frame_done_n, an_n, seg_n}, {3'b0, 1'b0, 4'hF, 8'hFF});
    check("drain_pre_rst", 16'(exp_q.size()), 16'h0);

    push_reset();
    push_frame(16'h0000, 4'h0, 4'h0, FRAME);
    push_frame(16'h0000, 4'h0, 4'h0, FRAME);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    scyc = 0;
    while (scyc < 2*FRAME + 1) step();
    mon_en = 1'b0;
    check("drain_end", 16'(exp_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
